// File: rtl/stream_prbs_pkg.sv
// Shared definitions for the stream PRBS-31 generator.
// Holds the FSM state type, the PRBS-31 taps, the default seed and
// the 32-step lane advance function used by every lane.
package stream_prbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // PRBS-31 polynomial x^31 + x^28 + 1, expressed as state bit taps
  localparam int PRBS_TAP_A = 30;
  localparam int PRBS_TAP_B = 27;

  // Used whenever a seed or a per-lane seed would otherwise be all-zero
  localparam logic [30:0] DEFAULT_SEED = 31'h1;

  // Runs the generator 32 steps from state s. The first generated bit
  // lands in word bit 31, the last in bit 0, so the state after the
  // 32 steps is simply the low 31 bits of the returned word.
  function automatic logic [31:0] prbs31_word(input logic [30:0] s);
    logic [30:0] st;
    logic        nb;
    logic [31:0] w;
    st = s;
    w  = '0;
    for (int k = 31; k >= 0; k--) begin
      nb   = st[PRBS_TAP_A] ^ st[PRBS_TAP_B];
      w[k] = nb;
      st   = {st[29:0], nb};
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_prbs_gen_if.sv
// AXI4-Stream style master bus of the PRBS generator.
interface stream_prbs_gen_if #(
  parameter int TDATA_WIDTH = 32
) ();

  logic [TDATA_WIDTH-1:0] M_AXIS_TDATA;
  logic                   M_AXIS_TVALID;
  logic                   M_AXIS_TREADY;

  modport master (
    output M_AXIS_TDATA,
    output M_AXIS_TVALID,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TDATA,
    input  M_AXIS_TVALID,
    output M_AXIS_TREADY
  );

endinterface

// File: rtl/stream_prbs_gen_lane.sv
// One 32-bit PRBS-31 lane: 31-bit generator state plus the registered
// output word. A load starts from seed_state, an advance continues from
// the current state; both produce the next 32-bit word in one cycle.
module prbs31_lane
  import stream_prbs_pkg::*;
(
  input  logic        clk,
  input  logic        areset,
  input  logic        load,
  input  logic        advance,
  input  logic [30:0] seed_state,
  output logic [31:0] word
);

  logic [30:0] state;
  logic [31:0] next_word;

  // Next word comes from the fresh seed on load, otherwise from the live state
  always_comb begin
    next_word = prbs31_word(load ? seed_state : state);
  end

  // Register the new word and keep its low 31 bits as the generator state
  always_ff @(posedge clk) begin
    if (areset) begin
      state <= DEFAULT_SEED;
      word  <= '0;
    end else if (load || advance) begin
      state <= next_word[30:0];
      word  <= next_word;
    end
  end

endmodule

// File: rtl/stream_prbs_gen.sv
// Multi-lane PRBS-31 stream source.
// start loads the lane seeds and streams num_words beats (0 = forever);
// stop ends the stream at the next accepted beat.
// Optional build macro STREAM_PRBS_GEN_ERR_INJECT_EN adds an inject input
// that flips bit 0 of lane 0 on the next beat without disturbing the PRBS.
module stream_prbs_gen
  import stream_prbs_pkg::*;
#(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [30:0]              seed,
  input  logic [31:0]              num_words,
`ifdef STREAM_PRBS_GEN_ERR_INJECT_EN
  input  logic                     inject,
`endif
  stream_prbs_gen_if.master        m_axis,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              sent_count
);

  localparam int NLINKS = TDATA_WIDTH / 32;

  state_t                 state;
  logic                   tvalid;
  logic                   stop_pending;
  logic [31:0]            words_target;
  logic                   load;
  logic                   fire;
  logic [30:0]            seed_eff;
  logic [TDATA_WIDTH-1:0] lane_words;

  assign load     = start && (state != RUN);
  assign fire     = tvalid && m_axis.M_AXIS_TREADY;
  assign seed_eff = (seed == 31'd0) ? DEFAULT_SEED : seed;

  for (genvar i = 0; i < NLINKS; i++) begin : g_lane
    logic [30:0] lane_seed;

    // Each lane starts from seed ^ lane index, never from the all-zero state
    always_comb begin
      lane_seed = seed_eff ^ 31'(i);
      if (lane_seed == 31'd0) lane_seed = DEFAULT_SEED;
    end

    prbs31_lane u_lane (
      .clk        (clk),
      .areset     (areset),
      .load       (load),
      .advance    (fire),
      .seed_state (lane_seed),
      .word       (lane_words[32*i +: 32])
    );
  end

  // Control FSM: owns the beat counter, the stop latch and the status outputs
  always_ff @(posedge clk) begin
    if (areset) begin
      state        <= IDLE;
      tvalid       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stop_pending <= 1'b0;
      words_target <= '0;
      sent_count   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            tvalid       <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            stop_pending <= 1'b0;
            words_target <= num_words;
            sent_count   <= '0;
          end
        end
        RUN: begin
          if (stop) stop_pending <= 1'b1;
          if (fire) begin
            sent_count <= sent_count + 32'd1;
            if ((words_target != 32'd0) && (sent_count + 32'd1 == words_target)) begin
              state  <= DONE;
              tvalid <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else if (stop || stop_pending) begin
              state        <= IDLE;
              tvalid       <= 1'b0;
              busy         <= 1'b0;
              stop_pending <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tvalid <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis.M_AXIS_TVALID = tvalid;

`ifdef STREAM_PRBS_GEN_ERR_INJECT_EN
  logic inject_pending;
  logic flip;

  // Hold an inject request until the next beat is loaded, then mark that beat
  always_ff @(posedge clk) begin
    if (areset) begin
      inject_pending <= 1'b0;
      flip           <= 1'b0;
    end else if (load || fire) begin
      flip           <= inject_pending || inject;
      inject_pending <= 1'b0;
    end else if (inject) begin
      inject_pending <= 1'b1;
    end
  end

  assign m_axis.M_AXIS_TDATA = lane_words ^ TDATA_WIDTH'(flip);
`else
  assign m_axis.M_AXIS_TDATA = lane_words;
`endif

endmodule

// File: tb/tb_stream_prbs_gen.sv
// Self-checking bench for stream_prbs_gen with two lanes (64-bit TDATA).
// A bit-serial PRBS-31 model fills a queue of expected beats; a monitor
// pops and compares every accepted beat.
module tb_stream_prbs_gen;

  localparam int TDATA_WIDTH = 64;
  localparam int NLINKS      = TDATA_WIDTH / 32;

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic        stop;
  logic [30:0] seed;
  logic [31:0] num_words;
  logic        busy;
  logic        done;
  logic [31:0] sent_count;

  int num_compared   = 0;
  int num_mismatched = 0;

  logic [63:0] exp_q[$];
  logic [30:0] model_state [NLINKS];
  logic [63:0] mon_exp;

`ifdef STREAM_PRBS_GEN_ERR_INJECT_EN
  logic        inject;
  int          err_count = 0;
  logic [63:0] golden_q[$];
  logic [63:0] mon_gold;
`endif

  stream_prbs_gen_if #(.TDATA_WIDTH(TDATA_WIDTH)) axis ();

  stream_prbs_gen #(.TDATA_WIDTH(TDATA_WIDTH)) dut (
    .clk        (clk),
    .areset     (areset),
    .start      (start),
    .stop       (stop),
    .seed       (seed),
    .num_words  (num_words),
`ifdef STREAM_PRBS_GEN_ERR_INJECT_EN
    .inject     (inject),
`endif
    .m_axis     (axis),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelSeed(input logic [30:0] sd);
    for (int i = 0; i < NLINKS; i++) begin
      logic [30:0] v;
      v = (sd == 31'd0) ? 31'd1 : sd;
      v = v ^ 31'(i);
      if (v == 31'd0) v = 31'd1;
      model_state[i] = v;
    end
  endtask

  task automatic modelNext(output logic [63:0] beat);
    beat = '0;
    for (int i = 0; i < NLINKS; i++) begin
      logic [30:0] s;
      logic [31:0] w;
      logic        nb;
      s = model_state[i];
      w = '0;
      for (int b = 31; b >= 0; b--) begin
        nb   = s[30] ^ s[27];
        w[b] = nb;
        s    = {s[29:0], nb};
      end
      model_state[i] = s;
      beat[32*i +: 32] = w;
    end
  endtask

  task automatic pushBeats(input int n);
    logic [63:0] b;
    for (int k = 0; k < n; k++) begin
      modelNext(b);
      exp_q.push_back(b);
`ifdef STREAM_PRBS_GEN_ERR_INJECT_EN
      golden_q.push_back(b);
`endif
    end
  endtask

  task automatic applyStimulus(input logic [30:0] sd, input logic [31:0] nw);
    seed      = sd;
    num_words = nw;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(done), 64'd1);
  endtask

  task automatic waitCount(input string tag, input logic [31:0] target, input int budget);
    int n = 0;
    while (sent_count !== target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(sent_count), 64'(target));
  endtask

  // Scoreboard monitor: a beat is accepted at the next posedge
  always @(negedge clk) begin
    if (areset === 1'b0 && axis.M_AXIS_TVALID === 1'b1 && axis.M_AXIS_TREADY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("beat_data", axis.M_AXIS_TDATA, mon_exp);
`ifdef STREAM_PRBS_GEN_ERR_INJECT_EN
        if (golden_q.size() != 0) begin
          mon_gold = golden_q.pop_front();
          if (axis.M_AXIS_TDATA !== mon_gold) err_count++;
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] hold;
    logic [63:0] beat0;
    logic        saw_valid;

    areset             = 1'b1;
    start              = 1'b0;
    stop               = 1'b0;
    seed               = '0;
    num_words          = '0;
    axis.M_AXIS_TREADY = 1'b0;
`ifdef STREAM_PRBS_GEN_ERR_INJECT_EN
    inject             = 1'b0;
`endif
    repeat (3) tick();
    checkOutput("rst_tvalid", 64'(axis.M_AXIS_TVALID), 64'd0);
    checkOutput("rst_tdata", axis.M_AXIS_TDATA, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_count", 64'(sent_count), 64'd0);
    areset = 1'b0;
    tick();

    // Seed 1, three beats, always ready; num_words change after start is ignored
    modelSeed(31'd1);
    pushBeats(3);
    axis.M_AXIS_TREADY = 1'b1;
    applyStimulus(31'd1, 32'd3);
    num_words = 32'd0;
    checkOutput("first_tvalid", 64'(axis.M_AXIS_TVALID), 64'd1);
    checkOutput("first_word", 64'(axis.M_AXIS_TDATA[31:0]), 64'h12);
    checkOutput("first_busy", 64'(busy), 64'd1);
    waitDone("n3_done", 20);
    checkOutput("n3_count", 64'(sent_count), 64'd3);
    checkOutput("n3_tvalid", 64'(axis.M_AXIS_TVALID), 64'd0);
    checkOutput("n3_busy", 64'(busy), 64'd0);

    // Stall for five cycles mid-run
    modelSeed(31'd5);
    pushBeats(20);
    applyStimulus(31'd5, 32'd20);
    waitCount("stall_reach", 32'd4, 30);
    axis.M_AXIS_TREADY = 1'b0;
    hold = exp_q[0];
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("stall_tdata", axis.M_AXIS_TDATA, hold);
      checkOutput("stall_tvalid", 64'(axis.M_AXIS_TVALID), 64'd1);
      checkOutput("stall_count", 64'(sent_count), 64'd4);
    end
    axis.M_AXIS_TREADY = 1'b1;
    waitDone("stall_done", 40);
    checkOutput("stall_final_count", 64'(sent_count), 64'd20);

    // Seed 0 behaves as seed 1; start wins over a simultaneous stop in DONE
    modelSeed(31'd1);
    pushBeats(2);
    stop = 1'b1;
    applyStimulus(31'd0, 32'd2);
    stop = 1'b0;
    checkOutput("start_over_stop", 64'(busy), 64'd1);
    waitDone("seed0_done", 20);
    checkOutput("seed0_count", 64'(sent_count), 64'd2);

    // Continuous mode, a start mid-run is ignored, stop after ten beats
    modelSeed(31'h7FFF_FFFF);
    pushBeats(10);
    applyStimulus(31'h7FFF_FFFF, 32'd0);
    begin
      int n = 0;
      while (sent_count !== 32'd9 && n < 40) begin
        start = (sent_count == 32'd5);
        tick();
        n++;
      end
    end
    start = 1'b0;
    checkOutput("cont_reach9", 64'(sent_count), 64'd9);
    axis.M_AXIS_TREADY = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_held_busy", 64'(busy), 64'd1);
    checkOutput("stop_held_tvalid", 64'(axis.M_AXIS_TVALID), 64'd1);
    axis.M_AXIS_TREADY = 1'b1;
    tick();
    checkOutput("stop_tvalid", 64'(axis.M_AXIS_TVALID), 64'd0);
    checkOutput("stop_busy", 64'(busy), 64'd0);
    checkOutput("stop_done", 64'(done), 64'd0);
    checkOutput("stop_count", 64'(sent_count), 64'd10);
    saw_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (axis.M_AXIS_TVALID !== 1'b0) saw_valid = 1'b1;
    end
    checkOutput("idle_no_tvalid", 64'(saw_valid), 64'd0);

    // Reset during a stalled beat, then restart reproduces beat 0
    axis.M_AXIS_TREADY = 1'b0;
    applyStimulus(31'd9, 32'd0);
    tick();
    tick();
    areset = 1'b1;
    tick();
    checkOutput("mid_rst_tvalid", 64'(axis.M_AXIS_TVALID), 64'd0);
    checkOutput("mid_rst_tdata", axis.M_AXIS_TDATA, 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    areset = 1'b0;
    tick();
    modelSeed(31'd9);
    pushBeats(1);
    beat0 = exp_q[0];
    axis.M_AXIS_TREADY = 1'b1;
    applyStimulus(31'd9, 32'd1);
    checkOutput("restart_word", axis.M_AXIS_TDATA, beat0);
    waitDone("restart_done", 20);

`ifdef STREAM_PRBS_GEN_ERR_INJECT_EN
    // Inject while beat 3 is on the bus marks beat 4 only
    modelSeed(31'd1);
    for (int k = 0; k < 8; k++) begin
      logic [63:0] b;
      modelNext(b);
      golden_q.push_back(b);
      exp_q.push_back((k == 4) ? (b ^ 64'h1) : b);
    end
    applyStimulus(31'd1, 32'd8);
    waitCount("inj_reach3", 32'd3, 20);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    waitDone("inj_done", 20);
    checkOutput("inj_count", 64'(sent_count), 64'd8);
    checkOutput("inj_err_count", 64'(err_count), 64'd1);
`endif

    tick();
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule

// File: doc/stream_prbs_gen.md
STREAM_PRBS_GEN -- requirements
Module: stream_prbs_gen

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 32: output width, integer multiple of 32.
REQ-002 SHALL have derived constant NLINKS = TDATA_WIDTH/32: number of independent 32-bit PRBS lanes.
REQ-003 SHALL have port clk, input, 1: clock for all logic.
REQ-004 SHALL have port areset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that loads seeds and begins generation.
REQ-006 SHALL have port stop, input, 1: single-cycle pulse that ends generation at the next beat boundary.
REQ-007 SHALL have port seed, input, 31: PRBS-31 seed.
REQ-008 SHALL have port num_words, input, 32: beats to emit; 0 means continuous.
REQ-009 SHALL have port M_AXIS_TDATA, output, TDATA_WIDTH: lane i occupies bits [32i+31:32i].
REQ-010 SHALL have port M_AXIS_TVALID, output, 1: beat valid.
REQ-011 SHALL have port M_AXIS_TREADY, input, 1: downstream ready.
REQ-012 SHALL have port busy, output, 1: high in RUN.
REQ-013 SHALL have port done, output, 1: high in DONE.
REQ-014 SHALL have port sent_count, output, 32: beats accepted since the last start.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL, in IDLE or DONE on start, load lane i state = seed ^ i (seed 0 replaced by 31'h1; a zero result replaced by 31'h1), clear sent_count, and enter RUN.
REQ-017 SHALL advance each lane 32 steps per beat: new = s[30]^s[27], s = {s[29:0],new}; the first generated bit is word bit 31.
REQ-018 SHALL drive TVALID=1 in RUN only, with TDATA registered and equal to the current lane words.
REQ-019 SHALL hold TDATA and TVALID stable while TVALID=1 and TREADY=0.
REQ-020 SHALL, on TVALID&&TREADY, advance the lanes and increment sent_count the same cycle; sent_count wraps 2^32-1 -> 0.
REQ-021 SHALL move RUN->DONE on the accepted beat where sent_count+1 == num_words (num_words != 0).
REQ-022 SHALL latch stop during RUN, and move RUN->IDLE on the next accepted beat, or immediately if TVALID is high with no stall pending (never retract an unaccepted beat).
REQ-023 SHALL give start priority over stop when both occur in IDLE/DONE; start during RUN SHALL be ignored.
REQ-024 SHALL sample num_words at start; later changes SHALL be ignored until the next start.
REQ-025 SHALL produce the first TVALID the cycle after start.

Reset
REQ-026 SHALL, on areset, enter IDLE with TVALID=0, TDATA=0, busy=0, done=0, sent_count=0, lane states=31'h1; reset mid-beat SHALL drop the beat.

Configuration
REQ-027 SHALL, with STREAM_PRBS_GEN_ERR_INJECT_EN defined, add input inject (1-bit pulse) that XORs 32'h1 into lane 0 of the next accepted beat only, without altering PRBS state.
REQ-028 SHALL, without STREAM_PRBS_GEN_ERR_INJECT_EN, have no inject port and no injection logic.

Structure
REQ-029 SHALL place the FSM state enum, the PRBS-31 taps and the default seed constant in package stream_prbs_pkg.
REQ-030 SHALL instantiate one prbs31_lane sub-module per lane (31-bit state, 32-step combinational advance, registered word).

Verification
REQ-031 SHALL check that seed=1, NLINKS=1, num_words=3, TREADY=1 gives first word 32'h00000012, done after 3 beats, and sent_count=3.
REQ-032 SHALL check that TREADY held low 5 cycles mid-run leaves TDATA/TVALID unchanged and sent_count unchanged.
REQ-033 SHALL check that num_words=0 with stop after 10 beats returns to IDLE with sent_count=10 and no further TVALID.
REQ-034 SHALL check that seed=0 produces output identical to seed=1.
REQ-035 SHALL check that, with ERR_INJECT_EN, inject at beat 4 flips only bit 0 of beat 4, that beat 5 matches the golden sequence, and that stream_compare err_count=1.
REQ-036 SHALL check that areset asserted during a stalled beat gives TVALID=0 next cycle and that a restart reproduces the beat-0 word.
